// File: rtl/seg7_rd_pkg.sv
// Shared types and constants for the 7-segment scan reader: 74LS48 glyph
// patterns (abcdefg, bit 6 = segment a), the blank code and the scan FSM states.
package seg7_rd_pkg;

    localparam int unsigned SEG_W  = 7;
    localparam int unsigned CODE_W = 4;

    localparam logic [CODE_W-1:0] BLANK_CODE = 4'hF;

    localparam logic [SEG_W-1:0] GLYPH_0 = 7'b1111110;
    localparam logic [SEG_W-1:0] GLYPH_1 = 7'b0110000;
    localparam logic [SEG_W-1:0] GLYPH_2 = 7'b1101101;
    localparam logic [SEG_W-1:0] GLYPH_3 = 7'b1111001;
    localparam logic [SEG_W-1:0] GLYPH_4 = 7'b0110011;
    localparam logic [SEG_W-1:0] GLYPH_5 = 7'b1011011;
    localparam logic [SEG_W-1:0] GLYPH_6 = 7'b0011111;
    localparam logic [SEG_W-1:0] GLYPH_7 = 7'b1110000;
    localparam logic [SEG_W-1:0] GLYPH_8 = 7'b1111111;
    localparam logic [SEG_W-1:0] GLYPH_9 = 7'b1110011;
    localparam logic [SEG_W-1:0] GLYPH_A = 7'b0001101;
    localparam logic [SEG_W-1:0] GLYPH_B = 7'b0011001;
    localparam logic [SEG_W-1:0] GLYPH_C = 7'b0100011;
    localparam logic [SEG_W-1:0] GLYPH_D = 7'b1001011;
    localparam logic [SEG_W-1:0] GLYPH_E = 7'b0001111;
    localparam logic [SEG_W-1:0] GLYPH_F = 7'b0000000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        HOLD   = 2'd3
    } state_e;

endpackage

// File: rtl/seg7_glyph_dec.sv
// Combinational 74LS48 glyph decoder: 7-bit segment pattern -> {valid, code}.
module seg7_glyph_dec
    import seg7_rd_pkg::*;
(
    input  logic [SEG_W-1:0]  pat,
    output logic              valid_c,
    output logic [CODE_W-1:0] code_c
);

    // Exact-match lookup; anything outside the glyph set is flagged invalid.
    always_comb begin
        valid_c = 1'b1;
        code_c  = BLANK_CODE;
        case (pat)
            GLYPH_0: code_c = 4'h0;
            GLYPH_1: code_c = 4'h1;
            GLYPH_2: code_c = 4'h2;
            GLYPH_3: code_c = 4'h3;
            GLYPH_4: code_c = 4'h4;
            GLYPH_5: code_c = 4'h5;
            GLYPH_6: code_c = 4'h6;
            GLYPH_7: code_c = 4'h7;
            GLYPH_8: code_c = 4'h8;
            GLYPH_9: code_c = 4'h9;
            GLYPH_A: code_c = 4'hA;
            GLYPH_B: code_c = 4'hB;
            GLYPH_C: code_c = 4'hC;
            GLYPH_D: code_c = 4'hD;
            GLYPH_E: code_c = 4'hE;
            GLYPH_F: code_c = 4'hF;
            default: valid_c = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_scan_reader.sv
// Reader for a multiplexed 7-segment bus: synchronizes the bus, waits for each
// digit select to settle, decodes the glyph, filters it over several scans and
// publishes stable codes with an update strobe.
// Optional build macro SEG7_RD_ZERO_RESTORE_EN: republish ripple-blanked
// leading digits as 0.
module seg7_scan_reader
    import seg7_rd_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned SETTLE_CYC   = 4,
    parameter int unsigned STABLE_SCANS = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       seg_a,
    input  logic                       seg_b,
    input  logic                       seg_c,
    input  logic                       seg_d,
    input  logic                       seg_e,
    input  logic                       seg_f,
    input  logic                       seg_g,
    input  logic [NUM_DIGITS-1:0]      dig_en_n,
    output logic [4*NUM_DIGITS-1:0]    bcd_out,
    output logic                       upd_valid,
    output logic [2:0]                 upd_idx,
    output logic [NUM_DIGITS-1:0]      pat_err,
    output logic                       sel_err
);

    localparam int unsigned IDX_W  = 3;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned RUN_W  = 4;
    localparam int unsigned LOWC_W = 4;

    // Synchronizer stages
    logic [SEG_W-1:0]      seg_s1_q, seg_s1_d, seg_s2_q, seg_s2_d;
    logic [NUM_DIGITS-1:0] en_s1_q, en_s1_d, en_s2_q, en_s2_d;

    // FSM and filter state
    state_e                             state_q, state_d;
    logic [CNT_W-1:0]                   cnt_q, cnt_d;
    logic [IDX_W-1:0]                   cur_idx_q, cur_idx_d;
    logic [NUM_DIGITS-1:0]              en_lat_q, en_lat_d;
    logic [NUM_DIGITS-1:0][CODE_W-1:0]  cand_q, cand_d;
    logic [NUM_DIGITS-1:0][RUN_W-1:0]   run_q, run_d;
    logic [NUM_DIGITS-1:0][CODE_W-1:0]  bcd_q, bcd_d;
    logic [NUM_DIGITS-1:0]              pat_q, pat_d;
    logic                               upd_valid_q, upd_valid_d;
    logic [IDX_W-1:0]                   upd_idx_q, upd_idx_d;
    logic                               sel_err_q, sel_err_d;

    // Combinational helpers
    logic                dec_valid_c;
    logic [CODE_W-1:0]   dec_code_c;
    logic [LOWC_W-1:0]   low_cnt;
    logic [IDX_W-1:0]    low_idx;
    logic                en_chg;
    logic                take_entry;
    logic [CODE_W-1:0]   cur_cand, cur_bcd, new_cand, pub_code;
    logic [RUN_W-1:0]    cur_run, new_run;
    logic                do_pub;
`ifdef SEG7_RD_ZERO_RESTORE_EN
    logic                hi_ok, lo_nb;
`endif

    seg7_glyph_dec u_dec (
        .pat     (seg_s2_q),
        .valid_c (dec_valid_c),
        .code_c  (dec_code_c)
    );

    // Two-flop synchronizer inputs
    always_comb begin
        seg_s1_d = {seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g};
        seg_s2_d = seg_s1_q;
        en_s1_d  = dig_en_n;
        en_s2_d  = en_s1_q;
    end

    // Synchronizer flops; enables reset to "none selected"
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_s1_q <= '0;
            seg_s2_q <= '0;
            en_s1_q  <= '1;
            en_s2_q  <= '1;
        end else begin
            seg_s1_q <= seg_s1_d;
            seg_s2_q <= seg_s2_d;
            en_s1_q  <= en_s1_d;
            en_s2_q  <= en_s2_d;
        end
    end

    // Count active (low) enables and locate the selected digit
    always_comb begin
        low_cnt = '0;
        low_idx = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (!en_s2_q[i]) begin
                low_cnt = low_cnt + LOWC_W'(1);
                low_idx = IDX_W'(i);
            end
        end
        en_chg = (en_s2_q != en_lat_q);
    end

    // Pick out the filter state of the digit being scanned
    always_comb begin
        cur_cand = BLANK_CODE;
        cur_bcd  = BLANK_CODE;
        cur_run  = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (cur_idx_q == IDX_W'(i)) begin
                cur_cand = cand_q[i];
                cur_bcd  = bcd_q[i];
                cur_run  = run_q[i];
            end
        end
    end

    // Stability filter and publish decision for the current sample
    always_comb begin
        new_cand = cur_cand;
        new_run  = cur_run;
        if (!dec_valid_c) begin
            new_run = '0;
        end else if (dec_code_c == cur_cand) begin
            new_run = (cur_run == RUN_W'(STABLE_SCANS)) ? cur_run : cur_run + RUN_W'(1);
        end else begin
            new_cand = dec_code_c;
            new_run  = RUN_W'(1);
        end

        pub_code = new_cand;
`ifdef SEG7_RD_ZERO_RESTORE_EN
        // Blank digit becomes 0 when everything above is blank/0 and something below is shown
        hi_ok = 1'b1;
        lo_nb = 1'b0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (IDX_W'(i) > cur_idx_q) begin
                if (bcd_q[i] != BLANK_CODE && bcd_q[i] != CODE_W'(0)) hi_ok = 1'b0;
            end else if (IDX_W'(i) < cur_idx_q) begin
                if (bcd_q[i] != BLANK_CODE) lo_nb = 1'b1;
            end
        end
        if (new_cand == BLANK_CODE && hi_ok && lo_nb) pub_code = CODE_W'(0);
`endif

        do_pub = dec_valid_c && (new_run == RUN_W'(STABLE_SCANS)) && (pub_code != cur_bcd);
    end

    // Next-state, filter update and output computation
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cur_idx_d   = cur_idx_q;
        en_lat_d    = en_lat_q;
        cand_d      = cand_q;
        run_d       = run_q;
        bcd_d       = bcd_q;
        pat_d       = pat_q;
        upd_valid_d = 1'b0;
        upd_idx_d   = upd_idx_q;
        sel_err_d   = 1'b0;
        take_entry  = 1'b0;

        case (state_q)
            IDLE: take_entry = en_chg;
            SETTLE: begin
                if (en_chg) begin
                    take_entry = 1'b1;
                end else if (cnt_q == CNT_W'(SETTLE_CYC - 1)) begin
                    state_d = SAMPLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            SAMPLE: begin
                state_d = HOLD;
                for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                    if (cur_idx_q == IDX_W'(i)) begin
                        cand_d[i] = new_cand;
                        run_d[i]  = new_run;
                        if (!dec_valid_c) pat_d[i] = 1'b1;
                        if (do_pub) bcd_d[i] = pub_code;
                    end
                end
                if (do_pub) begin
                    upd_valid_d = 1'b1;
                    upd_idx_d   = cur_idx_q;
                end
            end
            HOLD: take_entry = en_chg;
            default: state_d = IDLE;
        endcase

        // Common reaction to a new enable vector
        if (take_entry) begin
            en_lat_d = en_s2_q;
            cnt_d    = '0;
            if (low_cnt == LOWC_W'(0)) begin
                state_d = IDLE;
            end else if (low_cnt == LOWC_W'(1)) begin
                state_d   = SETTLE;
                cur_idx_d = low_idx;
            end else begin
                state_d   = IDLE;
                sel_err_d = 1'b1;
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Datapath and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q       <= '0;
            cur_idx_q   <= '0;
            en_lat_q    <= '1;
            cand_q      <= {NUM_DIGITS{BLANK_CODE}};
            run_q       <= '0;
            bcd_q       <= {NUM_DIGITS{BLANK_CODE}};
            pat_q       <= '0;
            upd_valid_q <= 1'b0;
            upd_idx_q   <= '0;
            sel_err_q   <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            cur_idx_q   <= cur_idx_d;
            en_lat_q    <= en_lat_d;
            cand_q      <= cand_d;
            run_q       <= run_d;
            bcd_q       <= bcd_d;
            pat_q       <= pat_d;
            upd_valid_q <= upd_valid_d;
            upd_idx_q   <= upd_idx_d;
            sel_err_q   <= sel_err_d;
        end
    end

    assign bcd_out   = bcd_q;
    assign upd_valid = upd_valid_q;
    assign upd_idx   = upd_idx_q;
    assign pat_err   = pat_q;
    assign sel_err   = sel_err_q;

endmodule

// File: tb/tb_seg7_scan_reader.sv
// Self-checking bench for seg7_scan_reader: a scan-level model predicts each
// publish / pattern error / select error and the cycle it must appear on;
// one negedge process compares every output each cycle.
module tb_seg7_scan_reader;

    localparam int unsigned N   = 4;
    localparam int unsigned S   = 4;
    localparam int unsigned STB = 2;
    localparam int unsigned LAT = S + 4;
    localparam int unsigned GAP = 12;

    localparam logic [6:0] GLY [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b0011111, 7'b1110000,
        7'b1111111, 7'b1110011, 7'b0001101, 7'b0011001,
        7'b0100011, 7'b1001011, 7'b0001111, 7'b0000000
    };

    localparam int K_PUB  = 0;
    localparam int K_PERR = 1;
    localparam int K_SEL  = 2;

    typedef struct {
        int unsigned cyc;
        int          kind;
        int          idx;
        logic [3:0]  code;
    } ev_t;

    logic            clk = 1'b0;
    logic            rst;
    logic [6:0]      segs;
    logic [N-1:0]    dig_en_n;
    logic [4*N-1:0]  bcd_out;
    logic            upd_valid;
    logic [2:0]      upd_idx;
    logic [N-1:0]    pat_err;
    logic            sel_err;

    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          upd_cnt = 0;
    int          sel_cnt = 0;
    int          upd_base;

    // Scan-level model state
    logic [3:0]   cand_m [N];
    logic [3:0]   pub_m  [N];
    int           run_m  [N];
    ev_t          evq [$];
    logic [4*N-1:0] exp_bcd;
    logic [N-1:0]   exp_pat;

    seg7_scan_reader #(
        .NUM_DIGITS   (N),
        .SETTLE_CYC   (S),
        .STABLE_SCANS (STB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .seg_a     (segs[6]),
        .seg_b     (segs[5]),
        .seg_c     (segs[4]),
        .seg_d     (segs[3]),
        .seg_e     (segs[2]),
        .seg_f     (segs[1]),
        .seg_g     (segs[0]),
        .dig_en_n  (dig_en_n),
        .bcd_out   (bcd_out),
        .upd_valid (upd_valid),
        .upd_idx   (upd_idx),
        .pat_err   (pat_err),
        .sel_err   (sel_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at cyc %0d: actual=%h required=%h", name, cyc, act, req);
        end
    endtask

    function automatic logic [3:0] restore(input int d, input logic [3:0] c);
`ifdef SEG7_RD_ZERO_RESTORE_EN
        bit hi_ok;
        bit lo_nb;
        hi_ok = 1'b1;
        lo_nb = 1'b0;
        if (c != 4'hF) return c;
        for (int j = d + 1; j < int'(N); j++)
            if (pub_m[j] != 4'hF && pub_m[j] != 4'h0) hi_ok = 1'b0;
        for (int j = 0; j < d; j++)
            if (pub_m[j] != 4'hF) lo_nb = 1'b1;
        return (hi_ok && lo_nb) ? 4'h0 : c;
`else
        return c;
`endif
    endfunction

    task automatic model_reset();
        for (int i = 0; i < int'(N); i++) begin
            cand_m[i] = 4'hF;
            pub_m[i]  = 4'hF;
            run_m[i]  = 0;
        end
        evq.delete();
        exp_bcd = '1;
        exp_pat = '0;
    endtask

    // Apply the filter rules to one scan of digit d taken with enable change after cycle n
    task automatic model_scan(input int d, input logic [6:0] p, input int unsigned n);
        int         code;
        ev_t        ev;
        logic [3:0] pc;
        code = -1;
        for (int c = 0; c < 16; c++) if (GLY[c] == p) code = c;
        ev.cyc  = n + LAT;
        ev.idx  = d;
        ev.code = 4'h0;
        if (code < 0) begin
            run_m[d] = 0;
            ev.kind  = K_PERR;
            evq.push_back(ev);
            return;
        end
        if (4'(code) == cand_m[d]) begin
            if (run_m[d] < int'(STB)) run_m[d]++;
        end else begin
            cand_m[d] = 4'(code);
            run_m[d]  = 1;
        end
        if (run_m[d] == int'(STB)) begin
            pc = restore(d, cand_m[d]);
            if (pc != pub_m[d]) begin
                pub_m[d] = pc;
                ev.kind  = K_PUB;
                ev.code  = pc;
                evq.push_back(ev);
            end
        end
    endtask

    task automatic scan(input int d, input logic [6:0] p);
        @(posedge clk); #1;
        segs     = p;
        dig_en_n = ~(N'(1) << d);
        model_scan(d, p, cyc);
        repeat (GAP - 1) @(posedge clk);
    endtask

    task automatic round_p(input logic [6:0] p0, input logic [6:0] p1,
                           input logic [6:0] p2, input logic [6:0] p3);
        scan(0, p0);
        scan(1, p1);
        scan(2, p2);
        scan(3, p3);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        model_reset();
        @(negedge clk); #1;
        chk("rst_bcd", 32'(bcd_out), 32'h0000FFFF);
        chk("rst_pat", 32'(pat_err), 32'h0);
        chk("rst_upd", 32'(upd_valid), 32'h0);
        chk("rst_idx", 32'(upd_idx), 32'h0);
        chk("rst_sel", 32'(sel_err), 32'h0);
        dig_en_n = '1;
        segs     = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    // Per-cycle comparison of every output against the model's schedule
    always @(negedge clk) begin
        logic       exp_upd;
        logic       exp_sel;
        logic [2:0] exp_idx;
        ev_t        ev;
        exp_upd = 1'b0;
        exp_sel = 1'b0;
        exp_idx = 3'd0;
        while (evq.size() > 0 && evq[0].cyc < cyc) begin
            ev = evq.pop_front();
            chk("event_time", cyc, ev.cyc);
        end
        if (evq.size() > 0 && evq[0].cyc == cyc) begin
            ev = evq.pop_front();
            case (ev.kind)
                K_PUB: begin
                    exp_bcd[ev.idx*4 +: 4] = ev.code;
                    exp_upd = 1'b1;
                    exp_idx = 3'(ev.idx);
                end
                K_PERR:  exp_pat[ev.idx] = 1'b1;
                default: exp_sel = 1'b1;
            endcase
        end
        chk("upd_valid", 32'(upd_valid), 32'(exp_upd));
        if (exp_upd) chk("upd_idx", 32'(upd_idx), 32'(exp_idx));
        chk("sel_err", 32'(sel_err), 32'(exp_sel));
        chk("bcd_out", 32'(bcd_out), 32'(exp_bcd));
        chk("pat_err", 32'(pat_err), 32'(exp_pat));
        if (upd_valid) upd_cnt++;
        if (sel_err)   sel_cnt++;
    end

    initial begin
        rst      = 1'b1;
        segs     = '0;
        dig_en_n = '1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("init_bcd", 32'(bcd_out), 32'h0000FFFF);
        chk("init_upd", 32'(upd_valid), 32'h0);
        chk("init_pat", 32'(pat_err), 32'h0);
        chk("init_sel", 32'(sel_err), 32'h0);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        // Two scans of 1,2,3,4 publish all four digits
        round_p(GLY[1], GLY[2], GLY[3], GLY[4]);
        @(negedge clk);
        chk("first_scan_bcd", 32'(bcd_out), 32'h0000FFFF);
        round_p(GLY[1], GLY[2], GLY[3], GLY[4]);
        @(negedge clk);
        chk("pub_bcd", 32'(bcd_out), 32'h00004321);
        chk("pub_cnt", upd_cnt, 4);

        // A single-scan 8 on digit 2 must not publish
        round_p(GLY[1], GLY[2], 7'b1111111, GLY[4]);
        round_p(GLY[1], GLY[2], GLY[3], GLY[4]);
        round_p(GLY[1], GLY[2], GLY[3], GLY[4]);
        @(negedge clk);
        chk("glitch_bcd", 32'(bcd_out), 32'h00004321);
        chk("glitch_cnt", upd_cnt, 4);

        // Two enables low: select error, no sample
        @(posedge clk); #1;
        dig_en_n = 4'b1100;
        begin
            ev_t ev;
            ev.cyc = cyc + 3; ev.kind = K_SEL; ev.idx = 0; ev.code = 4'h0;
            evq.push_back(ev);
        end
        repeat (GAP - 1) @(posedge clk);
        @(negedge clk);
        chk("sel_cnt", sel_cnt, 1);
        round_p(GLY[1], GLY[2], GLY[3], GLY[4]);
        @(negedge clk);
        chk("sel_bcd", 32'(bcd_out), 32'h00004321);

        // Unknown glyph on digit 1: sticky pattern error, code held
        round_p(GLY[1], 7'b1000000, GLY[3], GLY[4]);
        @(negedge clk);
        chk("perr_flag", 32'(pat_err), 32'h2);
        chk("perr_bcd", 32'(bcd_out), 32'h00004321);
        round_p(GLY[1], GLY[2], GLY[3], GLY[4]);
        round_p(GLY[1], GLY[2], GLY[3], GLY[4]);
        @(negedge clk);
        chk("perr_sticky", 32'(pat_err), 32'h2);
        chk("perr_cnt", upd_cnt, 4);

        // Reset while digit 2 is settling
        scan(0, GLY[7]);
        scan(1, GLY[15]);
        @(posedge clk); #1;
        segs     = GLY[15];
        dig_en_n = 4'b1011;
        repeat (4) @(posedge clk);
        do_reset();

        // Fresh filter after reset: blank,blank,blank,7 needs two scans
        upd_base = upd_cnt;
        round_p(GLY[7], GLY[15], GLY[15], GLY[15]);
        @(negedge clk);
        chk("post_rst_bcd", 32'(bcd_out), 32'h0000FFFF);
        chk("post_rst_cnt", upd_cnt - upd_base, 0);
        round_p(GLY[7], GLY[15], GLY[15], GLY[15]);
        @(negedge clk);
`ifdef SEG7_RD_ZERO_RESTORE_EN
        chk("blank_bcd", 32'(bcd_out), 32'h00000007);
        chk("blank_cnt", upd_cnt - upd_base, 4);
`else
        chk("blank_bcd", 32'(bcd_out), 32'h0000FFF7);
        chk("blank_cnt", upd_cnt - upd_base, 1);
`endif
        chk("blank_pat", 32'(pat_err), 32'h0);

        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("queue_empty", evq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
